// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_scanner_pkg;

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_PRESSED,
      ST_HOLD
   } state_t;

   localparam logic [3:0] COL_RESET = 4'b1110;
   localparam logic [3:0] ROWS_IDLE = 4'b1111;
   localparam logic [3:0] KEY_NONE  = 4'b0000;
   localparam logic [3:0] P1_END    = 4'b0011;
   localparam logic [3:0] P2_END    = 4'b0001;

   function automatic logic [3:0] col_drive(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

   // Lowest active (low) row wins when several rows share a column.
   function automatic logic [1:0] lowest_row(input logic [3:0] rows_n);
      if (!rows_n[0])      return 2'd0;
      else if (!rows_n[1]) return 2'd1;
      else if (!rows_n[2]) return 2'd2;
      else                 return 2'd3;
   endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for asynchronous multi-bit level inputs.
module sync_2ff #(
   parameter int unsigned     W       = 4,
   parameter logic [W-1:0]    RST_VAL = '1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_meta;
   logic [W-1:0] r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= RST_VAL;
         r_q    <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_q    <= r_meta;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix scanner: column scan, debounce, one pulse per press.
module keypad_scanner
   import keypad_scanner_pkg::*;
#(
   parameter int unsigned SCAN_DIV        = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [3:0]       w_rs;
   logic [1:0]       w_next_col;
   logic [CNT_W-1:0] w_cnt_inc;

   state_t           r_state;
   logic [1:0]       r_col;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_cap;
   logic [3:0]       r_col_n;
   logic [3:0]       r_code;
   logic             r_valid;
   logic             r_held;

   sync_2ff #(.W(4), .RST_VAL(ROWS_IDLE)) u_sync (
      .clk (clk),
      .rst (rst),
      .i_d (row_n),
      .o_q (w_rs)
   );

   assign w_next_col = r_col + 2'd1;
   assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

   // One counter serves as column dwell timer in SCAN and stability timer elsewhere.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_SCAN;
         r_col   <= 2'd0;
         r_cnt   <= '0;
         r_cap   <= ROWS_IDLE;
         r_col_n <= COL_RESET;
         r_code  <= KEY_NONE;
         r_valid <= 1'b0;
         r_held  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_code  <= KEY_NONE;
         case (r_state)
            ST_SCAN: begin
               if (r_cnt == DWELL_LAST) begin
                  r_cnt <= '0;
                  if (w_rs != ROWS_IDLE) begin
                     r_state <= ST_DEBOUNCE;
                     r_cap   <= w_rs;
                  end else begin
                     r_col   <= w_next_col;
                     r_col_n <= col_drive(w_next_col);
                  end
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            ST_DEBOUNCE: begin
               if (w_rs == r_cap) begin
                  if (r_cnt == DEB_LAST) begin
                     r_state <= ST_PRESSED;
                     r_cnt   <= '0;
                     r_valid <= 1'b1;
                     r_held  <= 1'b1;
                     r_code  <= {lowest_row(r_cap), r_col};
                  end else begin
                     r_cnt <= w_cnt_inc;
                  end
               end else begin
                  r_state <= ST_SCAN;
                  r_cnt   <= '0;
                  r_col   <= w_next_col;
                  r_col_n <= col_drive(w_next_col);
               end
            end
            ST_PRESSED: begin
               r_state <= ST_HOLD;
               r_cnt   <= '0;
            end
            ST_HOLD: begin
               if (w_rs == ROWS_IDLE) begin
                  if (r_cnt == DEB_LAST) begin
                     r_state <= ST_SCAN;
                     r_cnt   <= '0;
                     r_held  <= 1'b0;
                     r_col   <= w_next_col;
                     r_col_n <= col_drive(w_next_col);
                  end else begin
                     r_cnt <= w_cnt_inc;
                  end
               end else begin
                  r_cnt <= '0;
               end
            end
            default: r_state <= ST_SCAN;
         endcase
      end
   end

   assign col_n     = r_col_n;
   assign key_code  = r_code;
   assign key_valid = r_valid;
   assign key_held  = r_held;

endmodule
